// File: rtl/des_task_dispatcher.sv
// DES task dispatcher: one-entry task buffer, round-robin core pick, per-core busy tracking.
// Optional macro DES_DISPATCH_CONFLICT_EN blocks same-hint tasks from running concurrently.
module des_task_dispatcher #(
    parameter int N_CORES  = 4,
    parameter int TQ_W     = 64,
    parameter int HINT_LSB = 16,
    parameter int HINT_W   = 16
) (
    input  logic                           ap_clk,
    input  logic                           ap_rst_n,
    input  logic                           cfg_enable,
    input  logic                           stat_clear,
    input  logic                           task_in_valid,
    output logic                           task_in_ready,
    input  logic [TQ_W-1:0]                task_in_data,
    output logic [TQ_W-1:0]                core_task,
    output logic [N_CORES-1:0]             core_ap_start,
    input  logic [N_CORES-1:0]             core_ap_ready,
    input  logic [N_CORES-1:0]             core_ap_done,
    output logic [$clog2(N_CORES+1)-1:0]   busy_count,
    output logic                           all_idle,
    output logic [31:0]                    stat_dispatched,
    output logic [31:0]                    stat_conflict
);

    localparam int SEL_W = $clog2(N_CORES);
    localparam int CNT_W = $clog2(N_CORES + 1);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CORES - 1);

    typedef enum logic {
        C_IDLE = 1'b0,
        C_BUSY = 1'b1
    } core_state_e;

    core_state_e          core_state_q [N_CORES];
    core_state_e          core_state_d [N_CORES];
    logic                 hold_valid_q;
    logic                 hold_valid_d;
    logic [TQ_W-1:0]      hold_data_q;
    logic [SEL_W-1:0]     rr_ptr_q;
    logic [SEL_W-1:0]     rr_ptr_d;
    logic [31:0]          disp_q;
    logic [31:0]          conf_q;

    logic [N_CORES-1:0]   busy;
    logic [N_CORES-1:0]   elig;
    logic [HINT_W-1:0]    hold_hint;
    logic [SEL_W-1:0]     sel;
    logic                 any_elig;
    logic                 conflict;
    logic                 fire;
    logic                 accept;
    logic [CNT_W-1:0]     pop;

    function automatic int wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N_CORES) ? s - N_CORES : s;
    endfunction

    assign hold_hint = hold_data_q[HINT_LSB +: HINT_W];

    // Decode busy flags from the per-core FSM and derive eligibility
    always_comb begin
        busy = '0;
        for (int i = 0; i < N_CORES; i++) begin
            busy[i] = (core_state_q[i] == C_BUSY);
        end
        elig = core_ap_ready & ~busy;
    end

`ifdef DES_DISPATCH_CONFLICT_EN
    logic [HINT_W-1:0] active_hint_q [N_CORES];

    // Remember which vertex each core was started on
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int i = 0; i < N_CORES; i++) begin
                active_hint_q[i] <= '0;
            end
        end else if (fire) begin
            active_hint_q[sel] <= hold_hint;
        end
    end

    // Held task collides with a vertex already running on a busy core
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (busy[i] && (active_hint_q[i] == hold_hint)) begin
                conflict = 1'b1;
            end
        end
        conflict = conflict & hold_valid_q;
    end
`else
    logic unused_hint;
    assign unused_hint = ^hold_hint;
    assign conflict    = 1'b0;
`endif

    // Round-robin pick: first eligible core at or after rr_ptr
    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        for (int k = 0; k < N_CORES; k++) begin
            if (!any_elig && elig[SEL_W'(wrap_idx(int'(rr_ptr_q), k))]) begin
                sel      = SEL_W'(wrap_idx(int'(rr_ptr_q), k));
                any_elig = 1'b1;
            end
        end
    end

    assign fire          = hold_valid_q & cfg_enable & any_elig & ~conflict;
    assign task_in_ready = ~hold_valid_q | fire;
    assign accept        = task_in_valid & task_in_ready;

    // One-hot start toward the selected core
    always_comb begin
        core_ap_start = '0;
        if (fire) begin
            core_ap_start[sel] = 1'b1;
        end
    end

    // Next-state for holding slot, pointer and per-core busy FSMs
    always_comb begin
        hold_valid_d = hold_valid_q;
        rr_ptr_d     = rr_ptr_q;
        if (accept) begin
            hold_valid_d = 1'b1;
        end else if (fire) begin
            hold_valid_d = 1'b0;
        end
        if (fire) begin
            rr_ptr_d = (sel == LAST) ? '0 : sel + 1'b1;
        end
        for (int i = 0; i < N_CORES; i++) begin
            core_state_d[i] = core_state_q[i];
            case (core_state_q[i])
                C_IDLE: begin
                    if (fire && (sel == SEL_W'(i))) begin
                        core_state_d[i] = C_BUSY;
                    end
                end
                C_BUSY: begin
                    if (core_ap_done[i]) begin
                        core_state_d[i] = C_IDLE;
                    end
                end
                default: core_state_d[i] = C_IDLE;
            endcase
        end
    end

    // State registers
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            hold_valid_q <= 1'b0;
            rr_ptr_q     <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                core_state_q[i] <= C_IDLE;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int i = 0; i < N_CORES; i++) begin
                core_state_q[i] <= core_state_d[i];
            end
        end
    end

    // Task holding register, loaded on every accepted handshake
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            hold_data_q <= '0;
        end else if (accept) begin
            hold_data_q <= task_in_data;
        end
    end

    // Statistics: dispatch count wraps, conflict stall count saturates
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            disp_q <= '0;
            conf_q <= '0;
        end else if (stat_clear) begin
            disp_q <= '0;
            conf_q <= '0;
        end else begin
            if (fire) begin
                disp_q <= disp_q + 32'd1;
            end
            if (hold_valid_q && cfg_enable && conflict && (conf_q != '1)) begin
                conf_q <= conf_q + 32'd1;
            end
        end
    end

    // Population count of busy cores
    always_comb begin
        pop = '0;
        for (int i = 0; i < N_CORES; i++) begin
            pop = pop + CNT_W'(busy[i]);
        end
    end

    assign busy_count      = pop;
    assign all_idle        = ~hold_valid_q & ~|busy;
    assign core_task       = hold_data_q;
    assign stat_dispatched = disp_q;
    assign stat_conflict   = conf_q;

endmodule

// File: tb/tb_des_task_dispatcher.sv
// Directed testbench for des_task_dispatcher (N_CORES=4, hint at bits [31:16]).
// Expectations follow DES_DISPATCH_CONFLICT_EN when it is defined for the build.
module tb_des_task_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_enable;
    logic        stat_clear;
    logic        task_in_valid;
    logic        task_in_ready;
    logic [63:0] task_in_data;
    logic [63:0] core_task;
    logic [3:0]  core_ap_start;
    logic [3:0]  core_ap_ready;
    logic [3:0]  core_ap_done;
    logic [2:0]  busy_count;
    logic        all_idle;
    logic [31:0] stat_dispatched;
    logic [31:0] stat_conflict;

    int checks = 0;
    int errors = 0;

    des_task_dispatcher #(
        .N_CORES(4), .TQ_W(64), .HINT_LSB(16), .HINT_W(16)
    ) dut (
        .ap_clk(clk),
        .ap_rst_n(rst_n),
        .cfg_enable(cfg_enable),
        .stat_clear(stat_clear),
        .task_in_valid(task_in_valid),
        .task_in_ready(task_in_ready),
        .task_in_data(task_in_data),
        .core_task(core_task),
        .core_ap_start(core_ap_start),
        .core_ap_ready(core_ap_ready),
        .core_ap_done(core_ap_done),
        .busy_count(busy_count),
        .all_idle(all_idle),
        .stat_dispatched(stat_dispatched),
        .stat_conflict(stat_conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mk(input logic [15:0] hint, input logic [15:0] tag);
        return {16'hA5A5, tag, hint, 16'h0000};
    endfunction

    task automatic test_reset;
        #3;
        checks++; if (task_in_ready !== 1'b1) begin $display("FAIL rst_ready: got %b want 1", task_in_ready); errors++; end
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL rst_start: got %b want 0000", core_ap_start); errors++; end
        checks++; if (busy_count !== 3'd0) begin $display("FAIL rst_busy: got %0d want 0", busy_count); errors++; end
        checks++; if (all_idle !== 1'b1) begin $display("FAIL rst_idle: got %b want 1", all_idle); errors++; end
        checks++; if (core_task !== 64'h0) begin $display("FAIL rst_task: got %h want 0", core_task); errors++; end
        checks++; if (stat_dispatched !== 32'd0 || stat_conflict !== 32'd0) begin $display("FAIL rst_stats: got %0d/%0d want 0/0", stat_dispatched, stat_conflict); errors++; end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        cfg_enable = 1'b1; core_ap_ready = 4'hF;
        @(negedge clk); task_in_valid = 1'b1; task_in_data = mk(16'd1, 16'd1); #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL rr_first_lat: got %b want 0000", core_ap_start); errors++; end
        @(negedge clk); task_in_data = mk(16'd2, 16'd2); #1;
        checks++; if (core_ap_start !== 4'b0001) begin $display("FAIL rr_c0: got %b want 0001", core_ap_start); errors++; end
        checks++; if (core_task !== mk(16'd1, 16'd1)) begin $display("FAIL rr_task1: got %h want %h", core_task, mk(16'd1, 16'd1)); errors++; end
        @(negedge clk); task_in_data = mk(16'd3, 16'd3); #1;
        checks++; if (core_ap_start !== 4'b0010) begin $display("FAIL rr_c1: got %b want 0010", core_ap_start); errors++; end
        @(negedge clk); task_in_data = mk(16'd4, 16'd4); #1;
        checks++; if (core_ap_start !== 4'b0100) begin $display("FAIL rr_c2: got %b want 0100", core_ap_start); errors++; end
        @(negedge clk); task_in_data = mk(16'd5, 16'd5); #1;
        checks++; if (core_ap_start !== 4'b1000) begin $display("FAIL rr_c3: got %b want 1000", core_ap_start); errors++; end
        checks++; if (task_in_ready !== 1'b1) begin $display("FAIL rr_b2b_ready: got %b want 1", task_in_ready); errors++; end
        @(negedge clk); task_in_valid = 1'b0; #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL rr_full_stall: got %b want 0000", core_ap_start); errors++; end
        checks++; if (busy_count !== 3'd4) begin $display("FAIL rr_busy4: got %0d want 4", busy_count); errors++; end
        checks++; if (task_in_ready !== 1'b0) begin $display("FAIL rr_full_ready: got %b want 0", task_in_ready); errors++; end
        checks++; if (all_idle !== 1'b0) begin $display("FAIL rr_not_idle: got %b want 0", all_idle); errors++; end
        @(negedge clk); core_ap_done = 4'b0001; core_ap_ready = 4'b1110; #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL rr_done_cycle: got %b want 0000", core_ap_start); errors++; end
        @(negedge clk); core_ap_done = 4'b0000; core_ap_ready = 4'hF; #1;
        checks++; if (core_ap_start !== 4'b0001) begin $display("FAIL rr_fifth: got %b want 0001", core_ap_start); errors++; end
        checks++; if (core_task !== mk(16'd5, 16'd5)) begin $display("FAIL rr_task5: got %h want %h", core_task, mk(16'd5, 16'd5)); errors++; end
        @(negedge clk); #1;
        checks++; if (busy_count !== 3'd4) begin $display("FAIL rr_busy4b: got %0d want 4", busy_count); errors++; end
        checks++; if (stat_dispatched !== 32'd5) begin $display("FAIL rr_disp5: got %0d want 5", stat_dispatched); errors++; end
    endtask

    task automatic test_rr_skip;
        @(negedge clk); core_ap_done = 4'b1001; core_ap_ready = 4'b0110; #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL skip_none: got %b want 0000", core_ap_start); errors++; end
        @(negedge clk); core_ap_done = 4'b0000; core_ap_ready = 4'hF;
        task_in_valid = 1'b1; task_in_data = mk(16'd6, 16'd6); #1;
        checks++; if (busy_count !== 3'd2) begin $display("FAIL skip_busy2: got %0d want 2", busy_count); errors++; end
        @(negedge clk); task_in_data = mk(16'd7, 16'd7); #1;
        checks++; if (core_ap_start !== 4'b1000) begin $display("FAIL skip_c3: got %b want 1000", core_ap_start); errors++; end
        @(negedge clk); task_in_valid = 1'b0; #1;
        checks++; if (core_ap_start !== 4'b0001) begin $display("FAIL skip_c0: got %b want 0001", core_ap_start); errors++; end
        checks++; if (core_task !== mk(16'd7, 16'd7)) begin $display("FAIL skip_task7: got %h want %h", core_task, mk(16'd7, 16'd7)); errors++; end
        @(negedge clk); #1;
        checks++; if (stat_dispatched !== 32'd7) begin $display("FAIL skip_disp7: got %0d want 7", stat_dispatched); errors++; end
        @(negedge clk); core_ap_done = 4'hF; core_ap_ready = 4'h0;
        @(negedge clk); core_ap_done = 4'h0; core_ap_ready = 4'hF; #1;
        checks++; if (busy_count !== 3'd0 || all_idle !== 1'b1) begin $display("FAIL skip_drain: got %0d/%b want 0/1", busy_count, all_idle); errors++; end
    endtask

    task automatic test_conflict;
        @(negedge clk); core_ap_ready = 4'b1100;
        task_in_valid = 1'b1; task_in_data = mk(16'd7, 16'd8);
        @(negedge clk); task_in_data = mk(16'd7, 16'd9); #1;
        checks++; if (core_ap_start !== 4'b0100) begin $display("FAIL cf_first_c2: got %b want 0100", core_ap_start); errors++; end
        @(negedge clk); task_in_valid = 1'b0; core_ap_ready = 4'hF; #1;
`ifdef DES_DISPATCH_CONFLICT_EN
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL cf_stall1: got %b want 0000", core_ap_start); errors++; end
        checks++; if (task_in_ready !== 1'b0) begin $display("FAIL cf_ready: got %b want 0", task_in_ready); errors++; end
        @(negedge clk); #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL cf_stall2: got %b want 0000", core_ap_start); errors++; end
        @(negedge clk); core_ap_done = 4'b0100; core_ap_ready = 4'b1011; #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL cf_done_cycle: got %b want 0000", core_ap_start); errors++; end
        @(negedge clk); core_ap_done = 4'b0000; core_ap_ready = 4'hF; #1;
        checks++; if (core_ap_start !== 4'b1000) begin $display("FAIL cf_release: got %b want 1000", core_ap_start); errors++; end
        checks++; if (core_task !== mk(16'd7, 16'd9)) begin $display("FAIL cf_task: got %h want %h", core_task, mk(16'd7, 16'd9)); errors++; end
        checks++; if (stat_conflict !== 32'd3) begin $display("FAIL cf_count: got %0d want 3", stat_conflict); errors++; end
        @(negedge clk); #1;
        checks++; if (stat_conflict !== 32'd3) begin $display("FAIL cf_count_hold: got %0d want 3", stat_conflict); errors++; end
        checks++; if (busy_count !== 3'd1) begin $display("FAIL cf_busy1: got %0d want 1", busy_count); errors++; end
        @(negedge clk); core_ap_done = 4'b1000; core_ap_ready = 4'b0111;
`else
        checks++; if (core_ap_start !== 4'b1000) begin $display("FAIL nc_immediate: got %b want 1000", core_ap_start); errors++; end
        checks++; if (core_task !== mk(16'd7, 16'd9)) begin $display("FAIL nc_task: got %h want %h", core_task, mk(16'd7, 16'd9)); errors++; end
        @(negedge clk); #1;
        checks++; if (stat_conflict !== 32'd0) begin $display("FAIL nc_count: got %0d want 0", stat_conflict); errors++; end
        checks++; if (busy_count !== 3'd2) begin $display("FAIL nc_busy2: got %0d want 2", busy_count); errors++; end
        @(negedge clk); core_ap_done = 4'b1100; core_ap_ready = 4'b0011;
`endif
        @(negedge clk); core_ap_done = 4'b0000; core_ap_ready = 4'hF; #1;
        checks++; if (all_idle !== 1'b1) begin $display("FAIL cf_drain: got %b want 1", all_idle); errors++; end
        checks++; if (stat_dispatched !== 32'd9) begin $display("FAIL cf_disp9: got %0d want 9", stat_dispatched); errors++; end
    endtask

    task automatic test_enable;
        @(negedge clk); cfg_enable = 1'b0;
        task_in_valid = 1'b1; task_in_data = mk(16'd8, 16'd10); #1;
        checks++; if (task_in_ready !== 1'b1) begin $display("FAIL en_accept: got %b want 1", task_in_ready); errors++; end
        @(negedge clk); task_in_valid = 1'b0; #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL en_hold1: got %b want 0000", core_ap_start); errors++; end
        checks++; if (task_in_ready !== 1'b0) begin $display("FAIL en_ready0: got %b want 0", task_in_ready); errors++; end
        checks++; if (all_idle !== 1'b0) begin $display("FAIL en_idle0: got %b want 0", all_idle); errors++; end
        @(negedge clk); #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL en_hold2: got %b want 0000", core_ap_start); errors++; end
        cfg_enable = 1'b1; #1;
        checks++; if (core_ap_start !== 4'b0001) begin $display("FAIL en_start: got %b want 0001", core_ap_start); errors++; end
        checks++; if (task_in_ready !== 1'b1) begin $display("FAIL en_ready1: got %b want 1", task_in_ready); errors++; end
        @(negedge clk); #1;
        checks++; if (stat_dispatched !== 32'd10) begin $display("FAIL en_disp10: got %0d want 10", stat_dispatched); errors++; end
        core_ap_done = 4'b0001; core_ap_ready = 4'b1110;
        @(negedge clk); core_ap_done = 4'b0000; core_ap_ready = 4'hF; #1;
        checks++; if (all_idle !== 1'b1) begin $display("FAIL en_drain: got %b want 1", all_idle); errors++; end
    endtask

    task automatic test_stat_clear;
        @(negedge clk); stat_clear = 1'b1;
        @(negedge clk); stat_clear = 1'b0; #1;
        checks++; if (stat_dispatched !== 32'd0 || stat_conflict !== 32'd0) begin $display("FAIL clr_stats: got %0d/%0d want 0/0", stat_dispatched, stat_conflict); errors++; end
    endtask

    task automatic test_reset_mid;
        @(negedge clk); task_in_valid = 1'b1; task_in_data = mk(16'd9, 16'd11);
        @(negedge clk); task_in_data = mk(16'd10, 16'd12); #1;
        checks++; if (core_ap_start !== 4'b0010) begin $display("FAIL rm_c1: got %b want 0010", core_ap_start); errors++; end
        @(negedge clk); task_in_data = mk(16'd11, 16'd13); #1;
        checks++; if (core_ap_start !== 4'b0100) begin $display("FAIL rm_c2: got %b want 0100", core_ap_start); errors++; end
        @(negedge clk); task_in_valid = 1'b0; #1;
        checks++; if (core_ap_start !== 4'b1000 || busy_count !== 3'd2) begin $display("FAIL rm_pre: got %b/%0d want 1000/2", core_ap_start, busy_count); errors++; end
        rst_n = 1'b0; #1;
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL rm_start: got %b want 0000", core_ap_start); errors++; end
        checks++; if (busy_count !== 3'd0 || all_idle !== 1'b1) begin $display("FAIL rm_state: got %0d/%b want 0/1", busy_count, all_idle); errors++; end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        checks++; if (busy_count !== 3'd0 || all_idle !== 1'b1) begin $display("FAIL rm_after: got %0d/%b want 0/1", busy_count, all_idle); errors++; end
        checks++; if (stat_dispatched !== 32'd0 || core_task !== 64'h0) begin $display("FAIL rm_regs: got %0d/%h want 0/0", stat_dispatched, core_task); errors++; end
        checks++; if (core_ap_start !== 4'b0000) begin $display("FAIL rm_nostart: got %b want 0000", core_ap_start); errors++; end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_enable = 1'b0;
        stat_clear = 1'b0;
        task_in_valid = 1'b0;
        task_in_data = '0;
        core_ap_ready = 4'hF;
        core_ap_done = 4'h0;
        test_reset;
        test_round_robin;
        test_rr_skip;
        test_conflict;
        test_enable;
        test_stat_clear;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
